// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared definitions for the feature-map collector and pooling stage
// Contents: DATA_W (pixel word width), col_state_t (collector FSM states FILL/FULL).
package pool_pkg;

   localparam int DATA_W = 32;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } col_state_t;

endpackage

// File: rtl/relu_word.sv
// rtl/relu_word.sv - combinational ReLU clamp for one signed pixel word
// Ports: din (signed pixel in), dout (din if non-negative, else zero).
module relu_word
   import pool_pkg::*;
(
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   assign dout = din[DATA_W-1] ? '0 : din;

endmodule

// File: rtl/fmap_collector.sv
// rtl/fmap_collector.sv - collects a row-major pixel stream into a full feature-map frame
// Optional build macro: FMAP_RELU_EN (negative words are stored as zero).
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       word handshake; in_data pixel, in_last end-of-frame marker
//   frame_data              collected frame, index = row*input_size+col
//   frame_valid/frame_ready frame handshake to the pooling stage
//   frame_err               sticky framing error (early or missing in_last)
module fmap_collector
   import pool_pkg::*;
#(
   parameter int input_size = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic [DATA_W-1:0] frame_data [input_size*input_size],
   output logic              frame_valid,
   input  logic              frame_ready,
   output logic              frame_err
);

   localparam int WORDS = input_size * input_size;
   localparam int PTR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(WORDS - 1);

   col_state_t        state;
   col_state_t        next_state;
   logic [PTR_W-1:0]  wr_ptr;
   logic [DATA_W-1:0] store_word;
   logic              accept;
   logic              at_last;

`ifdef FMAP_RELU_EN
   relu_word u_relu (
      .din  (in_data),
      .dout (store_word)
   );
`else
   assign store_word = in_data;
`endif

   // Built from state directly (not from in_ready) so the FSM comb block has no feedback.
   assign accept  = in_valid && rst_n && (state == FILL);
   assign at_last = (wr_ptr == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state  = state;
      in_ready    = 1'b0;
      frame_valid = 1'b0;
      case (state)
         FILL: begin
            // Held low while reset is asserted.
            in_ready = rst_n;
            if (accept && at_last) begin
               next_state = FULL;
            end
         end
         FULL: begin
            frame_valid = 1'b1;
            // Release takes effect next cycle: one bubble, no pass-through.
            if (frame_ready) begin
               next_state = FILL;
            end
         end
         default: next_state = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         frame_err <= 1'b0;
         for (int i = 0; i < WORDS; i++) begin
            frame_data[i] <= '0;
         end
      end else if (accept) begin
         frame_data[wr_ptr] <= store_word;
         if (at_last) begin
            wr_ptr <= '0;
            if (!in_last) begin
               frame_err <= 1'b1;
            end
         end else if (in_last) begin
            // Early end-of-frame: restart the frame; stale words stay until overwritten.
            wr_ptr    <= '0;
            frame_err <= 1'b1;
         end else begin
            wr_ptr <= wr_ptr + 1'b1;
         end
      end
   end

endmodule
